// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-of-day controller, the hour formatter and the
// hour-system toggle FSM.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } set_state_e;

  localparam logic twelve_hr_system      = 1'b0;
  localparam logic twenty_four_hr_system = 1'b1;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  // Increment that wraps to zero after max.
  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
    return (val == max) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_hour_fmt.sv
// Combinational 24-hour to display-hour conversion; shared with the alarm block.
module hour_fmt
  import time_set_ctrl_pkg::*;
(
  input  logic [4:0] hour,
  input  logic       hr_sys,
  output logic [4:0] disp_hour,
  output logic       pm
);

  always_comb begin
    pm = (hour >= 5'd12);
    if (hr_sys == twenty_four_hr_system) begin
      disp_hour = hour;
    end else if (hour == 5'd0) begin
      disp_hour = 5'd12;
    end else if (hour > 5'd12) begin
      disp_hour = hour - 5'd12;
    end else begin
      disp_hour = hour;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-of-day counter with a RUN / SET_HOUR / SET_MIN set mode driven by
// debounced one-cycle button pulses, plus a blink flag for the field being set.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned BLINK_HALF    = 25
) (
  input  logic       clk_100hz,
  input  logic       rst,
  input  logic       mode_press,
  input  logic       inc_press,
  input  logic       hr_sys,
  output logic [1:0] set_state,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [4:0] disp_hour,
  output logic       pm,
  output logic       blink
);

  localparam int unsigned PRESC_W = $clog2(TICKS_PER_SEC + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

  set_state_e         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [4:0]         hour_q, hour_d;
  logic [5:0]         minute_q, minute_d;
  logic [5:0]         second_q, second_d;
  logic               blink_q, blink_d;
  logic               tick;

  assign tick = (state_q == RUN) && (presc_q == PRESC_W'(TICKS_PER_SEC - 1));

  always_comb begin
    // NOTE: every signal gets a hold default first so no path can infer a latch.
    state_d     = state_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    hour_d      = hour_q;
    minute_d    = minute_q;
    second_d    = second_q;
    blink_d     = blink_q;

    unique case (state_q)
      RUN: begin
        if (mode_press) begin
          state_d  = SET_HOUR;
          second_d = 6'd0;
          presc_d  = '0;
        end else if (tick) begin
          presc_d  = '0;
          second_d = wrap_inc(second_q, SEC_MAX);
          if (second_q == SEC_MAX) begin
            minute_d = wrap_inc(minute_q, MIN_MAX);
            if (minute_q == MIN_MAX) begin
              hour_d = 5'(wrap_inc({1'b0, hour_q}, HOUR_MAX));
            end
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      SET_HOUR: begin
        if (mode_press) begin
          state_d = SET_MIN;
        end else if (inc_press) begin
          hour_d = 5'(wrap_inc({1'b0, hour_q}, HOUR_MAX));
        end
      end
      SET_MIN: begin
        if (mode_press) begin
          state_d = RUN;
          presc_d = '0;
        end else if (inc_press) begin
          minute_d = wrap_inc(minute_q, MIN_MAX);
        end
      end
      default: state_d = RUN;
    endcase

    // Blink follows the next state so entry and exit edges already show it lit.
    if (state_d == RUN || state_d != state_q) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      hour_q      <= 5'd0;
      minute_q    <= 6'd0;
      second_q    <= 6'd0;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      hour_q      <= hour_d;
      minute_q    <= minute_d;
      second_q    <= second_d;
      blink_q     <= blink_d;
    end
  end

  assign set_state = state_q;
  assign hour      = hour_q;
  assign minute    = minute_q;
  assign second    = second_q;
  assign blink     = blink_q;

  hour_fmt u_hour_fmt (
    .hour      (hour_q),
    .hr_sys    (hr_sys),
    .disp_hour (disp_hour),
    .pm        (pm)
  );

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: a vector table for single-cycle behaviour
// followed by hand-written rollover, wrap, blink, format and reset sequences.
module tb_time_set_ctrl;

  logic       clk_100hz = 1'b0;
  logic       rst;
  logic       mode_press;
  logic       inc_press;
  logic       hr_sys;
  logic [1:0] set_state;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [4:0] disp_hour;
  logic       pm;
  logic       blink;

  int n_cmp  = 0;
  int n_fail = 0;

  time_set_ctrl #(
    .TICKS_PER_SEC (100),
    .BLINK_HALF    (25)
  ) dut (
    .clk_100hz  (clk_100hz),
    .rst        (rst),
    .mode_press (mode_press),
    .inc_press  (inc_press),
    .hr_sys     (hr_sys),
    .set_state  (set_state),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .disp_hour  (disp_hour),
    .pm         (pm),
    .blink      (blink)
  );

  always #5 clk_100hz = ~clk_100hz;

  typedef struct {
    logic       mode;
    logic       inc;
    logic       hrs;
    logic [1:0] st;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [4:0] dh;
    logic       p;
    logic       b;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [4:0] h,
                           input logic [5:0] m, input logic [5:0] s, input logic [4:0] dh,
                           input logic p, input logic b);
    check({tag, ".state"},  32'(set_state), 32'(st));
    check({tag, ".hour"},   32'(hour),      32'(h));
    check({tag, ".minute"}, 32'(minute),    32'(m));
    check({tag, ".second"}, 32'(second),    32'(s));
    check({tag, ".disp"},   32'(disp_hour), 32'(dh));
    check({tag, ".pm"},     32'(pm),        32'(p));
    check({tag, ".blink"},  32'(blink),     32'(b));
  endtask

  // Drive one cycle of inputs, then sample just after the active edge.
  task automatic cycle(input logic m, input logic i);
    @(negedge clk_100hz);
    mode_press = m;
    inc_press  = i;
    @(posedge clk_100hz);
    #1;
    mode_press = 1'b0;
    inc_press  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk_100hz);
    rst = 1'b0;
    repeat (2) @(negedge clk_100hz);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    mode_press = 1'b0;
    inc_press  = 1'b0;
    hr_sys     = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 6'd0, 6'd0, 5'd12, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 6'd0, 6'd0, 5'd12, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b01, 5'd1, 6'd0, 6'd0, 5'd1,  1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 2'b01, 5'd2, 6'd0, 6'd0, 5'd2,  1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2'b10, 5'd2, 6'd0, 6'd0, 5'd2,  1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 2'b10, 5'd2, 6'd1, 6'd0, 5'd2,  1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 2'b10, 5'd2, 6'd2, 6'd0, 5'd2,  1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 2'b00, 5'd2, 6'd2, 6'd0, 5'd2,  1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 2'b00, 5'd2, 6'd2, 6'd0, 5'd2,  1'b0, 1'b1};

    repeat (3) @(negedge clk_100hz);
    #1;
    check_all("reset_hold", 2'b00, 5'd0, 6'd0, 6'd0, 5'd12, 1'b0, 1'b1);
    rst = 1'b1;

    // Single-cycle vectors: ignore in RUN, set-mode steps, mode/inc priority.
    for (int i = 0; i < 9; i++) begin
      hr_sys = vecs[i].hrs;
      cycle(vecs[i].mode, vecs[i].inc);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].h, vecs[i].m, vecs[i].s,
                vecs[i].dh, vecs[i].p, vecs[i].b);
    end

    // Hour wraps through 23 -> 0; minute and second stay put.
    hr_sys = 1'b0;
    do_reset();
    cycle(1'b1, 1'b0);
    check("wrap.state", 32'(set_state), 32'd1);
    for (int k = 0; k < 25; k++) begin
      cycle(1'b0, 1'b1);
      check($sformatf("wrap%0d.minute", k), 32'(minute), 32'd0);
      check($sformatf("wrap%0d.second", k), 32'(second), 32'd0);
    end
    check("wrap.hour", 32'(hour), 32'd1);

    // Preload 23:59 and check minute wrap without carry.
    incs(22);
    check_all("h23", 2'b01, 5'd23, 6'd0, 6'd0, 5'd11, 1'b1, blink);
    cycle(1'b1, 1'b0);
    incs(58);
    check("min58", 32'(minute), 32'd58);
    incs(3);
    check("min_nocarry.minute", 32'(minute), 32'd1);
    check("min_nocarry.hour",   32'(hour),   32'd23);
    incs(58);
    check("min59", 32'(minute), 32'd59);

    // Back to RUN: first tick 100 cycles after entry, then roll over at 23:59:59.
    cycle(1'b1, 1'b0);
    check_all("run_entry", 2'b00, 5'd23, 6'd59, 6'd0, 5'd11, 1'b1, 1'b1);
    idle(99);
    check("tick1_early", 32'(second), 32'd0);
    idle(1);
    check("tick1", 32'(second), 32'd1);
    idle(5799);
    check("sec58", 32'(second), 32'd58);
    idle(1);
    check_all("t235959", 2'b00, 5'd23, 6'd59, 6'd59, 5'd11, 1'b1, 1'b1);
    idle(99);
    check_all("roll_early", 2'b00, 5'd23, 6'd59, 6'd59, 5'd11, 1'b1, 1'b1);
    idle(1);
    check_all("rollover", 2'b00, 5'd0, 6'd0, 6'd0, 5'd12, 1'b0, 1'b1);

    // Blink cadence in SET_HOUR: toggles at 25, 50 and 75 cycles after entry.
    cycle(1'b1, 1'b0);
    check("blink_entry", 32'(blink), 32'd1);
    idle(24);
    check("blink24", 32'(blink), 32'd1);
    idle(1);
    check("blink25", 32'(blink), 32'd0);
    idle(24);
    check("blink49", 32'(blink), 32'd0);
    idle(1);
    check("blink50", 32'(blink), 32'd1);
    idle(24);
    check("blink74", 32'(blink), 32'd1);
    idle(1);
    check("blink75", 32'(blink), 32'd0);

    // Hour 13 formatting in both systems.
    incs(13);
    check_all("h13_12h", 2'b01, 5'd13, 6'd0, 6'd0, 5'd1, 1'b1, blink);
    hr_sys = 1'b1;
    #1;
    check("h13_24h.disp", 32'(disp_hour), 32'd13);
    check("h13_24h.pm",   32'(pm),        32'd1);
    hr_sys = 1'b0;

    // SET_MIN entry relights blink; RUN re-entry forces it back to 1.
    cycle(1'b1, 1'b0);
    check("blink_min_entry", 32'(blink), 32'd1);
    idle(25);
    check("blink_min25", 32'(blink), 32'd0);
    cycle(1'b1, 1'b0);
    check_all("blink_run", 2'b00, 5'd13, 6'd0, 6'd0, 5'd1, 1'b1, 1'b1);

    // Asynchronous reset mid-count in SET_MIN.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    incs(4);
    idle(10);
    check("pre_rst.state", 32'(set_state), 32'd2);
    @(negedge clk_100hz);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 2'b00, 5'd0, 6'd0, 6'd0, 5'd12, 1'b0, 1'b1);
    @(negedge clk_100hz);
    rst = 1'b1;
    cycle(1'b0, 1'b1);
    check_all("post_rst", 2'b00, 5'd0, 6'd0, 6'd0, 5'd12, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
